// File: rtl/sdram_cam_pkg.sv
// Shared types and defaults for the camera-to-SDRAM frame writer.
package sdram_cam_pkg;
  localparam int DEF_ADDR_W = 22;
  localparam int DEF_DATA_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;
endpackage

// File: rtl/sdram_frame_writer_if.sv
// Pixel stream in and Avalon-MM write master out, bundled for the frame writer.
interface sdram_frame_writer_if import sdram_cam_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_sof;
  logic [ADDR_W-1:0] avm_address;
  logic [1:0]        avm_byteenable_n;
  logic              avm_chipselect;
  logic [DATA_W-1:0] avm_writedata;
  logic              avm_read_n;
  logic              avm_write_n;
  logic              avm_waitrequest;

  modport master (
    input  pix_data, pix_valid, pix_sof, avm_waitrequest,
    output avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
           avm_read_n, avm_write_n
  );

  modport slave (
    output pix_data, pix_valid, pix_sof, avm_waitrequest,
    input  avm_address, avm_byteenable_n, avm_chipselect, avm_writedata,
           avm_read_n, avm_write_n
  );
endinterface

// File: rtl/sdram_frame_writer_sync_fifo.sv
// Show-ahead synchronous FIFO; pushes while full are ignored, full is judged before any pop.
module sync_fifo import sdram_cam_pkg::*; #(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/sdram_frame_writer.sv
// Camera-to-SDRAM write master: buffers RGB565 pixels and writes one frame per armed SOF.
module sdram_frame_writer import sdram_cam_pkg::*; #(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                FRAME_WORDS = 307200,
  parameter int                FIFO_DEPTH  = 16
) (
  input  logic                 clk_in_clk,
  input  logic                 reset_reset,
  input  logic                 enable,
  sdram_frame_writer_if.master bus,
  output logic                 frame_done,
  output logic                 overflow,
  output logic                 resync_err
);
  localparam int WC_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_WORDS - 1);
  localparam int FW = DATA_W + 1;

  state_t                      state, state_nx;
  logic [WC_W-1:0]             wc, wc_acc;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]               fifo_wdata, fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic                        head_sof;
  logic [DATA_W-1:0]           head_data;
  logic                        accept, last_accept, load;
  logic                        arm_in, arm_head;
  logic [ADDR_W-1:0]           addr_q;
  logic [DATA_W-1:0]           data_q;
  logic                        write_n_q;

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in_clk),
    .rst   (reset_reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign fifo_wdata            = {bus.pix_sof, bus.pix_data};
  assign {head_sof, head_data} = fifo_rdata;
  assign accept                = ~write_n_q & ~bus.avm_waitrequest;
  assign last_accept           = accept & (wc == WC_LAST);
  assign wc_acc                = accept ? ((wc == WC_LAST) ? '0 : wc + 1'b1) : wc;
  assign arm_in                = bus.pix_sof & enable;
  // A buffered SOF left over from the previous frame re-arms as soon as it reaches the head.
  assign arm_head              = ~fifo_empty & head_sof & enable;

  always_ff @(posedge clk_in_clk) begin
    if (reset_reset) state <= IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if ((bus.pix_valid & arm_in) | arm_head) state_nx = RUN;
      RUN:  if (last_accept) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        fifo_push = bus.pix_valid & (arm_in | arm_head);
        fifo_pop  = ~fifo_empty & ~arm_head;
      end
      RUN: begin
        fifo_push = bus.pix_valid;
        load      = ~fifo_empty & (write_n_q | (accept & ~last_accept));
        fifo_pop  = load;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in_clk) begin
    if (reset_reset) begin
      wc         <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      frame_done <= last_accept;
      overflow   <= overflow | (fifo_push & fifo_full);
      if (load & head_sof) begin
        wc <= '0;
        if (wc_acc != '0) resync_err <= 1'b1;
      end else begin
        wc <= wc_acc;
      end
    end
  end

  // Avalon output register: only loads when idle or on acceptance, so waitrequest just holds it.
  always_ff @(posedge clk_in_clk) begin
    if (reset_reset) begin
      write_n_q <= 1'b1;
      addr_q    <= BASE_ADDR;
      data_q    <= '0;
    end else if (load) begin
      write_n_q <= 1'b0;
      data_q    <= head_data;
      addr_q    <= head_sof ? BASE_ADDR : BASE_ADDR + ADDR_W'(wc_acc);
    end else if (accept) begin
      write_n_q <= 1'b1;
    end
  end

  assign bus.avm_address      = addr_q;
  assign bus.avm_writedata    = data_q;
  assign bus.avm_write_n      = write_n_q;
  assign bus.avm_chipselect   = ~write_n_q;
  assign bus.avm_byteenable_n = 2'b00;
  assign bus.avm_read_n       = 1'b1;

  assert property (@(posedge clk_in_clk) disable iff (reset_reset)
                   int'(fifo_level) <= FIFO_DEPTH);
endmodule

// File: tb/tb_sdram_frame_writer.sv
// Scoreboard bench for sdram_frame_writer: frame-level reference model feeds an expected-write queue.
module tb_sdram_frame_writer;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;
  localparam int FW     = 8;
  localparam int DEPTH  = 4;
  localparam logic [ADDR_W-1:0] BASE = 22'h000100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic frame_done, overflow, resync_err;

  sdram_frame_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_frame_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE),
    .FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_in_clk (clk),
    .reset_reset(rst),
    .enable     (enable),
    .bus        (bus),
    .frame_done (frame_done),
    .overflow   (overflow),
    .resync_err (resync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_acc = 0;
  int   n_stored = 0;
  int   model_idx = -1;
  bit   exp_rsy = 1'b0;
  bit   hold_all = 1'b0;
  bit   rand_wait = 1'b0;
  int   hold_left = 0;
  int   stall_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame model: an armed SOF starts word 0, every later pixel takes the next address,
  // the FW-th word closes the frame, and an SOF inside a frame restarts at word 0.
  task automatic model_pixel(input logic [DATA_W-1:0] d, input bit sof);
    exp_t e;
    if (model_idx < 0 && !(sof && enable)) return;
    if (sof) begin
      if (model_idx > 0) exp_rsy = 1'b1;
      model_idx = 0;
    end
    e.addr = BASE + ADDR_W'(model_idx);
    e.data = d;
    e.last = (model_idx == FW - 1);
    sb.push_back(e);
    n_stored++;
    model_idx = (model_idx == FW - 1) ? -1 : model_idx + 1;
  endtask

  task automatic wait_room();
    int t = 0;
    while (n_stored - n_acc >= DEPTH && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 1000) chk("room_timeout", 32'(t), 32'(0));
  endtask

  // One pixel cycle; 'stored' says whether the model expects the DUT to keep it.
  task automatic send(input logic [DATA_W-1:0] d, input bit sof, input bit room, input bit stored);
    if (room) wait_room();
    bus.pix_data  = d;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    if (stored) model_pixel(d, sof);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (!(sb.size() == 0 && bus.avm_write_n) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) begin
      chk("drain_timeout", 32'(sb.size()), 32'(0));
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    sb.delete();
    model_idx = -1;
    exp_rsy   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    n_acc    = 0;
    n_stored = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_write_n"},    32'(bus.avm_write_n), 32'(1));
    chk({tag, "_chipselect"}, 32'(bus.avm_chipselect), 32'(0));
    chk({tag, "_address"},    32'(bus.avm_address), 32'(BASE));
    chk({tag, "_writedata"},  32'(bus.avm_writedata), 32'(0));
    chk({tag, "_frame_done"}, 32'(frame_done), 32'(0));
    chk({tag, "_overflow"},   32'(overflow), 32'(0));
    chk({tag, "_resync_err"}, 32'(resync_err), 32'(0));
  endtask

  // Slave side: waitrequest generator
  initial begin
    bus.avm_waitrequest = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_at >= 0 && !bus.avm_write_n && n_acc == stall_at) begin
        hold_left = 3;
        stall_at  = -1;
      end
      if (hold_all) bus.avm_waitrequest = 1'b1;
      else if (hold_left > 0) begin
        bus.avm_waitrequest = 1'b1;
        hold_left--;
      end else if (rand_wait) bus.avm_waitrequest = ($urandom_range(0, 3) == 0);
      else bus.avm_waitrequest = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every accepted write, checks holds and frame_done
  initial begin : monitor
    bit                frame_pend = 1'b0;
    bit                hold_pend = 1'b0;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_data;
    exp_t              e;
    forever begin
      @(negedge clk);
      if (rst) begin
        frame_pend = 1'b0;
        hold_pend  = 1'b0;
        continue;
      end
      if (frame_pend || frame_done) chk("frame_done", 32'(frame_done), 32'(frame_pend));
      frame_pend = 1'b0;
      if (hold_pend) begin
        chk("hold_write_n", 32'(bus.avm_write_n), 32'(0));
        chk("hold_address", 32'(bus.avm_address), 32'(h_addr));
        chk("hold_data",    32'(bus.avm_writedata), 32'(h_data));
        hold_pend = 1'b0;
      end
      if (!bus.avm_write_n) begin
        if (bus.avm_waitrequest) begin
          hold_pend = 1'b1;
          h_addr    = bus.avm_address;
          h_data    = bus.avm_writedata;
        end else begin
          n_acc++;
          chk("chipselect", 32'(bus.avm_chipselect), 32'(1));
          chk("ctrl_const", {29'd0, bus.avm_byteenable_n, bus.avm_read_n}, 32'(1));
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                     bus.avm_address, bus.avm_writedata);
          end else begin
            e = sb.pop_front();
            chk("wr_address", 32'(bus.avm_address), 32'(e.addr));
            chk("wr_data",    32'(bus.avm_writedata), 32'(e.data));
            frame_pend = e.last;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int len;
    bus.pix_data  = '0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;

    repeat (2) @(posedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    apply_reset(1);

    // Directed frame 0..7, second write stalled three cycles
    enable   = 1'b1;
    stall_at = 1;
    for (int i = 0; i < FW; i++) send(DATA_W'(i), i == 0, 1'b1, 1'b1);
    wait_drain();
    chk("frame1_overflow", 32'(overflow), 32'(0));
    chk("frame1_resync",   32'(resync_err), 32'(0));

    // Overflow: bus stalled, 7 pixels back to back; one held on the bus + DEPTH in the FIFO fit
    hold_all = 1'b1;
    for (int i = 0; i < 7; i++) send(DATA_W'(16'h0100 + i), i == 0, 1'b0, i < DEPTH + 1);
    repeat (2) @(posedge clk);
    #1;
    chk("overflow_set", 32'(overflow), 32'(1));
    hold_all = 1'b0;
    for (int i = 0; i < FW - (DEPTH + 1); i++) send(DATA_W'(16'h0200 + i), 1'b0, 1'b1, 1'b1);
    wait_drain();
    chk("overflow_sticky", 32'(overflow), 32'(1));
    chk("overflow_resync", 32'(resync_err), 32'(0));

    // Resync: SOF reissued after 3 words
    for (int i = 0; i < 3; i++) send(DATA_W'(16'h0300 + i), i == 0, 1'b1, 1'b1);
    for (int i = 0; i < FW; i++) send(DATA_W'(16'h0400 + i), i == 0, 1'b1, 1'b1);
    wait_drain();
    chk("resync_set",        32'(resync_err), 32'(1));
    chk("resync_ovf_sticky", 32'(overflow), 32'(1));

    // IDLE discards: no SOF while armed, then SOF with enable low
    apply_reset(1);
    for (int i = 0; i < 4; i++) send(DATA_W'(16'h0500 + i), 1'b0, 1'b0, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) send(DATA_W'(16'h0600 + i), i == 0, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("idle_no_writes", 32'(n_acc), 32'(0));
    chk("idle_overflow",  32'(overflow), 32'(0));
    chk("idle_resync",    32'(resync_err), 32'(0));

    // enable dropped mid-frame: frame still completes
    enable = 1'b1;
    send(16'h0700, 1'b1, 1'b1, 1'b1);
    enable = 1'b0;
    for (int i = 1; i < FW; i++) send(DATA_W'(16'h0700 + i), 1'b0, 1'b1, 1'b1);
    wait_drain();
    chk("en_drop_writes", 32'(n_acc), 32'(FW));

    // Randomized frames with random waitrequest, gaps and truncated frames
    enable    = 1'b1;
    rand_wait = 1'b1;
    for (int f = 0; f < 8; f++) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, FW - 1)) : FW;
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(DATA_W'($urandom_range(0, 16'hFFFF)), i == 0, 1'b1, 1'b1);
      end
    end
    for (int i = 0; i < FW; i++) send(DATA_W'($urandom_range(0, 16'hFFFF)), i == 0, 1'b1, 1'b1);
    wait_drain();
    rand_wait = 1'b0;
    chk("rand_resync",   32'(resync_err), 32'(exp_rsy));
    chk("rand_overflow", 32'(overflow), 32'(0));

    // Reset while a write is held by waitrequest
    hold_all = 1'b1;
    for (int i = 0; i < 3; i++) send(DATA_W'(16'h0800 + i), i == 0, 1'b1, 1'b1);
    begin
      int t = 0;
      while (bus.avm_write_n && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      chk("pre_reset_write_n", 32'(bus.avm_write_n), 32'(0));
    end
    apply_reset(1);
    hold_all = 1'b0;
    check_reset_vals("midwrite_reset");
    @(posedge clk); #1;
    for (int i = 0; i < FW; i++) send(DATA_W'(16'h0A00 + i), i == 0, 1'b1, 1'b1);
    wait_drain();
    chk("post_reset_writes", 32'(n_acc), 32'(FW));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
